cpu_seq: RTL and testbench
==========================

// Module: cpu_seq
// PURPOSE
//  Multi-cycle instruction sequencer for the NPC core: steps every instruction through BOOT/IF/ID/EX/MEM/WB.
//  Owns the instruction register feeding idu, handshakes instruction fetch and lsu memory access, and
//  gates register-file and PC write enables so architectural state updates exactly once per instruction.
//  Halts on ebreak or on a memory handshake timeout.
// PARAMETERS
//  TIMEOUT_CYC   255            cycles a request may wait for ack before error-halt (1..65535)
//  NOP_INS       32'h0000_0013  instruction register value after reset (addi x0,x0,0)
// PORTS
//  i_clk        in   1               core clock
//  i_rst_n      in   1               reset; asynchronous assert, active-low
//  o_if_req     out  1               instruction fetch request; held until i_if_ack
//  i_if_ack     in   1               fetch done; i_if_ins valid this cycle
//  i_if_ins     in   32              fetched instruction
//  o_ins        out  32              latched instruction register, drives idu i_ins
//  i_rdwen      in   1               idu register write intent for current o_ins
//  i_lsu_opt    in   `LSU_OPT_WIDTH  idu lsu opcode; `LSU_NOP = no memory access
//  i_ebreak     in   1               current o_ins is ebreak (opcode `TYPE_I_EBRK)
//  o_lsu_req    out  1               data memory request; held until i_lsu_ack
//  i_lsu_ack    in   1               lsu access complete (load data valid this cycle)
//  o_rdwen      out  1               gated regfile write enable, 1-cycle pulse in WB
//  o_pc_wen     out  1               PC update enable (pcu), 1-cycle pulse in WB
//  o_halt       out  1               sticky: core stopped (ebreak or timeout)
//  o_err        out  1               sticky: halted due to handshake timeout
//  o_instret    out  32              retired instruction count
//  o_state      out  3               current state, debug/trace only
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=BOOT, o_ins=NOP_INS, o_instret=0, o_halt=0, o_err=0, timeout cnt=0.
//  All control outputs are decoded from registered state; all are 0 in BOOT, so nothing is requested during reset.
//  States/transitions (one per clock edge):
//   BOOT -> IF unconditionally.
//   IF:  o_if_req=1. i_if_ack=1 -> latch i_if_ins into o_ins, -> ID. Else stay, timeout cnt++.
//   ID:  1 cycle, idu settles. i_ebreak=1 -> HALT (o_halt=1, o_err=0). Else -> EX.
//   EX:  1 cycle, exu settles. i_lsu_opt != `LSU_NOP -> MEM; else -> WB.
//   MEM: o_lsu_req=1. i_lsu_ack=1 -> WB. Else stay, timeout cnt++.
//   WB:  o_rdwen=i_rdwen, o_pc_wen=1, o_instret++ -> IF.
//   HALT: absorbing; all requests/enables 0; only reset leaves it.
//  Latency: no-memory instruction = IF(>=1)+ID+EX+WB = 4 cycles with ack in first IF cycle; load/store = 5.
//  Ack rules: i_if_ack/i_lsu_ack sampled only in IF/MEM respectively; ack in any other state ignored.
//   Ack in first cycle of request is legal. Requests never drop before ack (except reset/timeout).
//  Timeout: cnt clears on every state entry; when cnt reaches TIMEOUT_CYC-1 with no ack, next state=HALT,
//   o_halt=1, o_err=1. Ack on that same cycle wins (normal transition, no error).
//  o_instret wraps 32'hFFFF_FFFF -> 0 silently. o_ins stable from ID through WB; changes only on IF ack.
//  Reset mid-instruction: immediate abort to BOOT; no o_rdwen/o_pc_wen pulse for the aborted instruction.
//  Inputs from idu (i_rdwen, i_lsu_opt, i_ebreak) are combinational from o_ins; sampled only in ID/EX/WB.
//  State encoding: BOOT=0 IF=1 ID=2 EX=3 MEM=4 WB=5 HALT=6; 7 unreachable -> HALT with o_err=1.
// STRUCTURE
//  defines.v: `SEQ_STATE_W (3), `SEQ_BOOT..`SEQ_HALT encodings; reuse existing `LSU_NOP, `LSU_OPT_WIDTH.
//  Sub-module seq_wdog: timeout counter (clear, enable, expired flag), width $clog2(TIMEOUT_CYC).
//  Top: state register + next-state always block, IR register, instret counter, output decode.
// TESTING
//  1. Reset, ack fetch each cycle, ins=addi(i_rdwen=1, LSU_NOP) -> o_rdwen and o_pc_wen pulse in cycle 4 after BOOT; o_instret=1.
//  2. Load (i_lsu_opt!=NOP), i_lsu_ack after 3 wait cycles -> o_lsu_req high 4 cycles, one WB pulse, o_instret+1.
//  3. Hold i_if_ack=0 with TIMEOUT_CYC=8 -> o_if_req high 8 cycles, then o_halt=1, o_err=1, o_if_req=0 forever.
//  4. Fetch ins with i_ebreak=1 -> HALT from ID, o_halt=1, o_err=0, no o_pc_wen, o_instret unchanged.
//  5. Assert i_rst_n=0 while in MEM -> same-cycle state=BOOT, o_lsu_req=0, o_ins=32'h13, no WB pulse.
//  6. Preload o_instret=32'hFFFF_FFFF (force) then retire one -> o_instret=0; stray i_lsu_ack in IF ignored.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
package cpu_seq_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned LSU_OPT_W   = 4;
  localparam int unsigned SEQ_STATE_W = 3;

  localparam logic [LSU_OPT_W-1:0] LSU_NOP = '0;

  typedef enum logic [SEQ_STATE_W-1:0] {
    S_BOOT = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } seq_state_e;

  // Fetch response payload: ack qualifies ins in the same cycle.
  typedef struct packed {
    logic            ack;
    logic [XLEN-1:0] ins;
  } fetch_rsp_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_seq_if.sv
// Fetch and data-memory handshakes between the sequencer and the memory side.
interface cpu_seq_if;
  import cpu_seq_pkg::*;

  logic       if_req;
  fetch_rsp_t if_rsp;
  logic       lsu_req;
  logic       lsu_ack;

  modport master (output if_req, output lsu_req, input if_rsp, input lsu_ack);
  modport slave  (input if_req, input lsu_req, output if_rsp, output lsu_ack);

endinterface

// File: rtl/cpu_seq_wdog.sv
// Handshake watchdog: counts waiting cycles, flags expiry at TIMEOUT_CYC-1.
module cpu_seq_wdog
  import cpu_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  localparam int unsigned CW = cnt_width(TIMEOUT_CYC);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired_c) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expired_c = (r_cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle sequencer: steps each instruction BOOT/IF/ID/EX/MEM/WB and
// gates architectural writes so they happen exactly once per instruction.
module cpu_seq
  import cpu_seq_pkg::*;
#(
  parameter int unsigned     TIMEOUT_CYC = 255,
  parameter logic [XLEN-1:0] NOP_INS     = 32'h0000_0013
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  cpu_seq_if.master              m_bus,
  output logic [XLEN-1:0]        o_ins,
  input  logic                   i_rdwen,
  input  logic [LSU_OPT_W-1:0]   i_lsu_opt,
  input  logic                   i_ebreak,
  output logic                   o_rdwen,
  output logic                   o_pc_wen,
  output logic                   o_halt,
  output logic                   o_err,
  output logic [XLEN-1:0]        o_instret,
  output logic [SEQ_STATE_W-1:0] o_state
);

  seq_state_e      r_state;
  seq_state_e      w_next;
  logic            w_to_err;
  logic            w_expired;
  logic [XLEN-1:0] r_ins;
  logic [XLEN-1:0] r_instret;
  logic            r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_BOOT;
    else          r_state <= w_next;
  end

  // Next state; an ack arriving on the expiry cycle takes priority over the timeout.
  always_comb begin
    w_next   = r_state;
    w_to_err = 1'b0;
    case (r_state)
      S_BOOT: w_next = S_IF;
      S_IF: begin
        if (m_bus.if_rsp.ack) begin
          w_next = S_ID;
        end else if (w_expired) begin
          w_next   = S_HALT;
          w_to_err = 1'b1;
        end
      end
      S_ID:  w_next = i_ebreak ? S_HALT : S_EX;
      S_EX:  w_next = (i_lsu_opt != LSU_NOP) ? S_MEM : S_WB;
      S_MEM: begin
        if (m_bus.lsu_ack) begin
          w_next = S_WB;
        end else if (w_expired) begin
          w_next   = S_HALT;
          w_to_err = 1'b1;
        end
      end
      S_WB:   w_next = S_IF;
      S_HALT: w_next = S_HALT;
      default: begin
        w_next   = S_HALT;
        w_to_err = 1'b1;
      end
    endcase
  end

  cpu_seq_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (w_next != r_state),
    .i_en        ((r_state == S_IF) || (r_state == S_MEM)),
    .o_expired_c (w_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ins     <= NOP_INS;
      r_instret <= '0;
      r_err     <= 1'b0;
    end else begin
      if ((r_state == S_IF) && m_bus.if_rsp.ack) r_ins <= m_bus.if_rsp.ins;
      if (r_state == S_WB) r_instret <= r_instret + XLEN'(1);
      if (w_to_err) r_err <= 1'b1;
    end
  end

  // Control outputs decode the state register only, so all are low in BOOT.
  assign m_bus.if_req  = (r_state == S_IF);
  assign m_bus.lsu_req = (r_state == S_MEM);
  assign o_rdwen       = (r_state == S_WB) && i_rdwen;
  assign o_pc_wen      = (r_state == S_WB);
  assign o_halt        = (r_state == S_HALT);
  assign o_err         = r_err;
  assign o_ins         = r_ins;
  assign o_instret     = r_instret;
  assign o_state       = SEQ_STATE_W'(r_state);

endmodule

// File: tb/tb_cpu_seq.sv
// Randomized bench for cpu_seq against a per-instruction latency/retire model.
module tb_cpu_seq;
  import cpu_seq_pkg::*;

  localparam int unsigned TMO   = 8;
  localparam logic [31:0] EBRK  = 32'h0010_0073;
  localparam logic [31:0] NOPW  = 32'h0000_0013;

  logic                 i_clk;
  logic                 i_rst_n;
  logic [31:0]          o_ins;
  logic                 i_rdwen;
  logic [LSU_OPT_W-1:0] i_lsu_opt;
  logic                 i_ebreak;
  logic                 o_rdwen, o_pc_wen, o_halt, o_err;
  logic [31:0]          o_instret;
  logic [2:0]           o_state;
  logic [6:0]           w_opc;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned exp_ret = 0;

  cpu_seq_if bus ();

  cpu_seq #(.TIMEOUT_CYC(TMO), .NOP_INS(NOPW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .m_bus(bus), .o_ins(o_ins),
    .i_rdwen(i_rdwen), .i_lsu_opt(i_lsu_opt), .i_ebreak(i_ebreak),
    .o_rdwen(o_rdwen), .o_pc_wen(o_pc_wen), .o_halt(o_halt), .o_err(o_err),
    .o_instret(o_instret), .o_state(o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Minimal idu: decode from the instruction register.
  assign w_opc     = o_ins[6:0];
  assign i_ebreak  = (o_ins == EBRK);
  assign i_lsu_opt = (w_opc == 7'h03) ? 4'd1 : (w_opc == 7'h23) ? 4'd2 : LSU_NOP;
  assign i_rdwen   = (o_ins[11:7] != 5'd0) && (w_opc != 7'h23) && !i_ebreak;

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle_bus();
    bus.if_rsp  = '0;
    bus.lsu_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_bus();
    i_rst_n = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
    step();
    exp_ret = 0;
  endtask

  // Acts as memory for one instruction starting in IF; returns what was seen at the WB pulse.
  task automatic run_instr(input logic [31:0] ins, input int if_wait, input int lsu_wait,
                           input bit stray, output int pre_cyc, output int lsu_cyc,
                           output logic rdwen_seen, output logic [31:0] ins_seen, output bit ok);
    int fw = 0;
    int lw = 0;
    pre_cyc = 0; lsu_cyc = 0; rdwen_seen = 1'b0; ins_seen = '0; ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (o_pc_wen) begin
        rdwen_seen = o_rdwen;
        ins_seen   = o_ins;
        ok         = 1'b1;
        break;
      end
      pre_cyc++;
      if (bus.lsu_req) lsu_cyc++;
      idle_bus();
      if (bus.if_req) begin
        if (fw == if_wait) begin
          bus.if_rsp.ack = 1'b1;
          bus.if_rsp.ins = ins;
        end else fw++;
        if (stray) bus.lsu_ack = 1'($urandom_range(0, 1));
      end else if (bus.lsu_req) begin
        if (lw == lsu_wait) bus.lsu_ack = 1'b1;
        else lw++;
      end else if (stray) begin
        bus.if_rsp.ack = 1'b1;
        bus.if_rsp.ins = $urandom;
      end
      step();
    end
    idle_bus();
    step();
  endtask

  // Drives one instruction and checks latency, lsu occupancy, write gating and retire count.
  task automatic check_instr(input string tag, input logic [31:0] ins, input bit mem,
                             input logic exp_rdwen, input int if_wait, input int lsu_wait,
                             input bit stray);
    int pre, lsc, exp_pre, exp_lsc;
    logic rdw;
    logic [31:0] ins_s;
    bit ok;
    exp_pre = if_wait + 1 + 2 + (mem ? lsu_wait + 1 : 0);
    exp_lsc = mem ? lsu_wait + 1 : 0;
    run_instr(ins, if_wait, lsu_wait, stray, pre, lsc, rdw, ins_s, ok);
    exp_ret = exp_ret + 1;
    n_tests++;
    if (!ok || pre !== exp_pre) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d (pulse=%0b) want %0d", tag, pre, ok, exp_pre);
    end
    n_tests++;
    if (lsc !== exp_lsc) begin
      n_fail++;
      $display("FAIL %s_lsu_req_cycles: got %0d want %0d", tag, lsc, exp_lsc);
    end
    n_tests++;
    if (rdw !== exp_rdwen || ins_s !== ins) begin
      n_fail++;
      $display("FAIL %s_wb: rdwen=%0b ins=%h want rdwen=%0b ins=%h", tag, rdw, ins_s, exp_rdwen, ins);
    end
    n_tests++;
    if (o_instret !== exp_ret || o_pc_wen !== 1'b0 || o_state !== 3'd1) begin
      n_fail++;
      $display("FAIL %s_retire: instret=%h pc_wen=%0b state=%0d want instret=%h pc_wen=0 state=1",
               tag, o_instret, o_pc_wen, o_state, exp_ret);
    end
  endtask

  task automatic test_reset();
    idle_bus();
    i_rst_n = 1'b1;
    #2 i_rst_n = 1'b0;
    step();
    n_tests++;
    if (o_state !== 3'd0 || o_ins !== NOPW || o_instret !== 32'd0 || o_halt !== 1'b0 ||
        o_err !== 1'b0 || bus.if_req !== 1'b0 || bus.lsu_req !== 1'b0 || o_pc_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: state=%0d ins=%h instret=%h halt=%0b err=%0b ifreq=%0b want 0/%h/0/0/0/0",
               o_state, o_ins, o_instret, o_halt, o_err, bus.if_req, NOPW);
    end
    i_rst_n = 1'b1;
    step();
    n_tests++;
    if (o_state !== 3'd1 || bus.if_req !== 1'b1) begin
      n_fail++;
      $display("FAIL boot_to_if: state=%0d ifreq=%0b want 1/1", o_state, bus.if_req);
    end
    exp_ret = 0;
  endtask

  task automatic test_addi();
    check_instr("addi", 32'h0010_0093, 1'b0, 1'b1, 0, 0, 1'b0);
  endtask

  task automatic test_load();
    check_instr("load", 32'h0000_a103, 1'b1, 1'b1, 0, 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      int kind, rd;
      logic [31:0] ins;
      kind = int'($urandom_range(0, 2));
      rd   = int'($urandom_range(0, 31));
      ins  = $urandom;
      ins[11:7] = 5'(rd);
      ins[6:0]  = (kind == 0) ? 7'h13 : (kind == 1) ? 7'h03 : 7'h23;
      check_instr($sformatf("b2b%0d", i), ins, kind != 0, (kind != 2) && (rd != 0),
                  int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 1'b1);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.r_instret = 32'hFFFF_FFFF;
    step();
    release dut.r_instret;
    step();
    n_tests++;
    if (o_instret !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL wrap_preload: got %h want ffffffff", o_instret);
    end
    exp_ret = 32'hFFFF_FFFF;
    check_instr("wrap", 32'h0050_0293, 1'b0, 1'b1, 2, 0, 1'b1);
    check_instr("after_wrap", 32'h0000_0013, 1'b0, 1'b0, 1, 0, 1'b1);
  endtask

  task automatic test_ebreak();
    bit pc_seen = 1'b0;
    idle_bus();
    bus.if_rsp.ack = 1'b1;
    bus.if_rsp.ins = EBRK;
    step();
    idle_bus();
    for (int c = 0; c < 10; c++) begin
      if (o_pc_wen) pc_seen = 1'b1;
      step();
    end
    n_tests++;
    if (o_halt !== 1'b1 || o_err !== 1'b0 || pc_seen || o_instret !== exp_ret || o_state !== 3'd6) begin
      n_fail++;
      $display("FAIL ebreak_halt: halt=%0b err=%0b pc_wen_seen=%0b instret=%h state=%0d want 1/0/0/%h/6",
               o_halt, o_err, pc_seen, o_instret, exp_ret, o_state);
    end
  endtask

  task automatic test_timeout();
    int req_cyc = 0;
    bit bad = 1'b0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      if (o_halt) break;
      if (bus.if_req) req_cyc++;
      step();
    end
    n_tests++;
    if (req_cyc !== int'(TMO) || o_halt !== 1'b1 || o_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: req_cycles=%0d halt=%0b err=%0b want %0d/1/1", req_cyc, o_halt, o_err, TMO);
    end
    for (int c = 0; c < 6; c++) begin
      bus.if_rsp.ack = 1'b1;
      step();
      if (bus.if_req !== 1'b0 || o_halt !== 1'b1 || o_state !== 3'd6) bad = 1'b1;
    end
    idle_bus();
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL timeout_absorbing: ifreq=%0b halt=%0b state=%0d want 0/1/6", bus.if_req, o_halt, o_state);
    end
  endtask

  task automatic test_reset_mid_mem();
    bit bad = 1'b0;
    do_reset();
    bus.if_rsp.ack = 1'b1;
    bus.if_rsp.ins = 32'h0000_a183;
    step();
    idle_bus();
    step();
    step();
    n_tests++;
    if (o_state !== 3'd4 || bus.lsu_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reach_mem: state=%0d lsureq=%0b want 4/1", o_state, bus.lsu_req);
    end
    #2 i_rst_n = 1'b0;
    #1;
    n_tests++;
    if (o_state !== 3'd0 || bus.lsu_req !== 1'b0 || o_ins !== NOPW || o_pc_wen !== 1'b0 || o_rdwen !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_mem_reset: state=%0d lsureq=%0b ins=%h pc_wen=%0b want 0/0/%h/0",
               o_state, bus.lsu_req, o_ins, o_pc_wen, NOPW);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    bus.lsu_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (o_pc_wen !== 1'b0 || o_rdwen !== 1'b0) bad = 1'b1;
    end
    idle_bus();
    n_tests++;
    if (bad || o_instret !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_no_wb: pulse_seen=%0b instret=%h want 0/0", bad, o_instret);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load();
    test_back_to_back();
    test_wrap();
    test_ebreak();
    test_timeout();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
